// File: rtl/lsq_mem_arbiter_pkg.sv
// Shared constants and the FSM state encoding for the load/store data-cache arbiter.
package lsq_mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ROB_SEL    = 6;

  // IDLE: grant decision; REQ: request held to cache; WAIT: awaiting response.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/lsq_mem_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; counts how long a pending store
// has been losing arbitration to loads.
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  // Clear has priority; increments stop once the limit is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Arbitrates the single data-cache port between load issue and committed-store
// drain, keeps one transaction outstanding, and routes the response back.
//
// Handshakes: a requester transfers when its *_req_valid and *_req_ready are both
// high at a rising edge; *_req_ready is only ever high in IDLE. Toward the cache,
// mem_req_valid rises in REQ and stays high with stable payload until the edge
// where mem_req_ready is high; mem_resp_valid is only consumed in WAIT.
module lsq_mem_arbiter
  import lsq_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_WIDTH,
  parameter int DATA_W       = DATA_WIDTH,
  parameter int ROB_W        = ROB_SEL,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  input  logic [ROB_W-1:0]  ld_req_rob_idx,
  output logic              ld_req_ready,
  input  logic              st_req_valid,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [DATA_W-1:0] st_req_data,
  output logic              st_req_ready,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              flush,
  output logic              ld_resp_valid,
  output logic [DATA_W-1:0] ld_resp_data,
  output logic [ROB_W-1:0]  ld_resp_rob_idx,
  output logic              st_done,
  output logic              busy
);

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  arb_state_e        state, state_n;
  logic [CW-1:0]     starve_cnt;
  logic              ld_accept, st_accept;
  logic              resp_fire;
  logic              we_q;
  logic              killed;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ROB_W-1:0]  rob_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_n;
  end

  // Grant decision and next state; a starved store beats a pending load.
  always_comb begin
    state_n   = state;
    ld_accept = 1'b0;
    st_accept = 1'b0;
    resp_fire = 1'b0;
    case (state)
      ARB_IDLE: begin
        st_accept = st_req_valid && (!ld_req_valid || (starve_cnt == CNT_MAX));
        ld_accept = ld_req_valid && !st_accept;
        if (st_accept || ld_accept) state_n = ARB_REQ;
      end
      ARB_REQ: begin
        if (mem_req_ready) state_n = ARB_WAIT;
      end
      ARB_WAIT: begin
        resp_fire = mem_resp_valid;
        if (mem_resp_valid) state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Readies are masked while reset is held so every output reads 0 in reset.
  assign ld_req_ready  = ld_accept && !reset;
  assign st_req_ready  = st_accept && !reset;
  assign mem_req_valid = (state == ARB_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign busy          = (state != ARB_IDLE);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (CW)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (st_req_valid && ld_accept),
    .clr   (st_accept),
    .cnt   (starve_cnt)
  );

  // Request payload capture at acceptance, plus the load-kill flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rob_q   <= '0;
      we_q    <= 1'b0;
      killed  <= 1'b0;
    end else if (ld_accept) begin
      addr_q  <= ld_req_addr;
      rob_q   <= ld_req_rob_idx;
      we_q    <= 1'b0;
      killed  <= flush;
    end else if (st_accept) begin
      addr_q  <= st_req_addr;
      wdata_q <= st_req_data;
      we_q    <= 1'b1;
      killed  <= 1'b0;
    end else if ((state != ARB_IDLE) && flush && !we_q) begin
      killed  <= 1'b1;
    end
  end

  // Response routing: one-cycle pulses; a same-cycle flush also kills a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_resp_valid   <= 1'b0;
      ld_resp_data    <= '0;
      ld_resp_rob_idx <= '0;
      st_done         <= 1'b0;
    end else begin
      ld_resp_valid <= resp_fire && !we_q && !killed && !flush;
      st_done       <= resp_fire && we_q;
      if (resp_fire && !we_q && !killed && !flush) begin
        ld_resp_data    <= mem_resp_data;
        ld_resp_rob_idx <= rob_q;
      end
    end
  end

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter: a per-cycle vector table followed by a
// continuous load/store pressure sequence exercising the starvation counter.
module tb_lsq_mem_arbiter;

  localparam logic        N   = 1'b0;
  localparam logic        Y   = 1'b1;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [5:0]  Z6  = 6'h0;

  typedef struct packed {
    logic        rst;
    logic        ldv;
    logic [31:0] lda;
    logic [5:0]  ldr;
    logic        stv;
    logic [31:0] sta;
    logic [31:0] std;
    logic        mrdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        fl;
  } in_t;

  typedef struct packed {
    logic        ldrdy;
    logic        strdy;
    logic        mv;
    logic        we;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        lrv;
    logic [31:0] lrd;
    logic [5:0]  lrr;
    logic        sd;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req_valid;
  logic [31:0] ld_req_addr;
  logic [5:0]  ld_req_rob_idx;
  logic        ld_req_ready;
  logic        st_req_valid;
  logic [31:0] st_req_addr;
  logic [31:0] st_req_data;
  logic        st_req_ready;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        flush;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [5:0]  ld_resp_rob_idx;
  logic        st_done;
  logic        busy;

  always #5 clk = ~clk;

  lsq_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .ROB_W        (6),
    .STARVE_LIMIT (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ld_req_valid    (ld_req_valid),
    .ld_req_addr     (ld_req_addr),
    .ld_req_rob_idx  (ld_req_rob_idx),
    .ld_req_ready    (ld_req_ready),
    .st_req_valid    (st_req_valid),
    .st_req_addr     (st_req_addr),
    .st_req_data     (st_req_data),
    .st_req_ready    (st_req_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .flush           (flush),
    .ld_resp_valid   (ld_resp_valid),
    .ld_resp_data    (ld_resp_data),
    .ld_resp_rob_idx (ld_resp_rob_idx),
    .st_done         (st_done),
    .busy            (busy)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  vec_t        vecs[$];
  logic [32:0] exp_q[$];

  // ---------------- driver / checker tasks ----------------
  task automatic add(input in_t a, input out_t b);
    vec_t v;
    v.i = a;
    v.o = b;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t v);
    reset          = v.rst;
    ld_req_valid   = v.ldv;
    ld_req_addr    = v.lda;
    ld_req_rob_idx = v.ldr;
    st_req_valid   = v.stv;
    st_req_addr    = v.sta;
    st_req_data    = v.std;
    mem_req_ready  = v.mrdy;
    mem_resp_valid = v.rspv;
    mem_resp_data  = v.rspd;
    flush          = v.fl;
  endtask

  task automatic check_out(input string name, input out_t e);
    out_t a;
    a = '{ld_req_ready, st_req_ready, mem_req_valid, mem_req_we, mem_req_addr,
          mem_req_wdata, ld_resp_valid, ld_resp_data, ld_resp_rob_idx, st_done, busy};
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got rdy=%b%b mv=%b we=%b a=%h wd=%h lrv=%b lrd=%h rob=%0d sd=%b busy=%b, want rdy=%b%b mv=%b we=%b a=%h wd=%h lrv=%b lrd=%h rob=%0d sd=%b busy=%b",
               name, a.ldrdy, a.strdy, a.mv, a.we, a.ma, a.mwd, a.lrv, a.lrd, a.lrr, a.sd, a.busy,
               e.ldrdy, e.strdy, e.mv, e.we, e.ma, e.mwd, e.lrv, e.lrd, e.lrr, e.sd, e.busy);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive('{Y, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N});

    // Single load, latency T..T+3.
    add('{Y, Y, 32'h100, 6'd5, N, Z32, Z32, N, N, Z32, N},
        '{N, N, N, N, Z32, Z32, N, Z32, Z6, N, N});
    add('{N, Y, 32'h100, 6'd5, N, Z32, Z32, N, N, Z32, N},
        '{Y, N, N, N, Z32, Z32, N, Z32, Z6, N, N});
    add('{N, N, Z32, Z6, N, Z32, Z32, Y, N, Z32, N},
        '{N, N, Y, N, 32'h100, Z32, N, Z32, Z6, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, Y, 32'hDEADBEEF, N},
        '{N, N, N, N, 32'h100, Z32, N, Z32, Z6, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N},
        '{N, N, N, N, 32'h100, Z32, Y, 32'hDEADBEEF, 6'd5, N, N});
    // Backpressure: three cycles without mem_req_ready, other requesters waiting.
    add('{N, Y, 32'h200, 6'd7, N, Z32, Z32, N, N, Z32, N},
        '{Y, N, N, N, 32'h100, Z32, N, 32'hDEADBEEF, 6'd5, N, N});
    for (int k = 0; k < 3; k++)
      add('{N, Y, 32'h300, 6'd9, Y, 32'h400, 32'h11112222, N, N, Z32, N},
          '{N, N, Y, N, 32'h200, Z32, N, 32'hDEADBEEF, 6'd5, N, Y});
    add('{N, Y, 32'h300, 6'd9, Y, 32'h400, 32'h11112222, Y, N, Z32, N},
        '{N, N, Y, N, 32'h200, Z32, N, 32'hDEADBEEF, 6'd5, N, Y});
    add('{N, Y, 32'h300, 6'd9, Y, 32'h400, 32'h11112222, N, Y, 32'hCAFE0001, N},
        '{N, N, N, N, 32'h200, Z32, N, 32'hDEADBEEF, 6'd5, N, Y});
    // Simultaneous requests, counter at 0: load wins.
    add('{N, Y, 32'h300, 6'd9, Y, 32'h400, 32'h11112222, N, N, Z32, N},
        '{Y, N, N, N, 32'h200, Z32, Y, 32'hCAFE0001, 6'd7, N, N});
    // Flush during the load's WAIT: response swallowed.
    add('{N, N, Z32, Z6, Y, 32'h400, 32'h11112222, Y, N, Z32, N},
        '{N, N, Y, N, 32'h300, Z32, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{N, N, Z32, Z6, Y, 32'h400, 32'h11112222, N, N, Z32, Y},
        '{N, N, N, N, 32'h300, Z32, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{N, N, Z32, Z6, Y, 32'h400, 32'h11112222, N, Y, 32'hBAD0BAD0, N},
        '{N, N, N, N, 32'h300, Z32, N, 32'hCAFE0001, 6'd7, N, Y});
    // Waiting store now granted; flush during it does not stop st_done.
    add('{N, N, Z32, Z6, Y, 32'h400, 32'h11112222, N, N, Z32, N},
        '{N, Y, N, N, 32'h300, Z32, N, 32'hCAFE0001, 6'd7, N, N});
    add('{N, N, Z32, Z6, N, Z32, Z32, Y, N, Z32, Y},
        '{N, N, Y, Y, 32'h400, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, Y, Z32, Y},
        '{N, N, N, Y, 32'h400, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N},
        '{N, N, N, Y, 32'h400, 32'h11112222, N, 32'hCAFE0001, 6'd7, Y, N});
    // Response in IDLE ignored; flush coinciding with a load response kills it.
    add('{N, Y, 32'h500, 6'd3, N, Z32, Z32, N, Y, 32'h55555555, N},
        '{Y, N, N, Y, 32'h400, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, N});
    add('{N, N, Z32, Z6, N, Z32, Z32, Y, N, Z32, N},
        '{N, N, Y, N, 32'h500, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, Y, 32'h66666666, Y},
        '{N, N, N, N, 32'h500, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N},
        '{N, N, N, N, 32'h500, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, N});
    // Flush in the acceptance cycle kills the load.
    add('{N, Y, 32'h600, 6'd2, N, Z32, Z32, N, N, Z32, Y},
        '{Y, N, N, N, 32'h500, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, N});
    add('{N, N, Z32, Z6, N, Z32, Z32, Y, N, Z32, N},
        '{N, N, Y, N, 32'h600, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, Y, 32'h77777777, N},
        '{N, N, N, N, 32'h600, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N},
        '{N, N, N, N, 32'h600, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, N});
    // Reset mid-WAIT, late response dropped, next load normal.
    add('{N, Y, 32'h700, 6'd4, N, Z32, Z32, N, N, Z32, N},
        '{Y, N, N, N, 32'h600, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, N});
    add('{N, N, Z32, Z6, N, Z32, Z32, Y, N, Z32, N},
        '{N, N, Y, N, 32'h700, 32'h11112222, N, 32'hCAFE0001, 6'd7, N, Y});
    add('{Y, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N},
        '{N, N, N, N, Z32, Z32, N, Z32, Z6, N, N});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, Y, 32'h88888888, N},
        '{N, N, N, N, Z32, Z32, N, Z32, Z6, N, N});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N},
        '{N, N, N, N, Z32, Z32, N, Z32, Z6, N, N});
    add('{N, Y, 32'h800, 6'd1, N, Z32, Z32, N, N, Z32, N},
        '{Y, N, N, N, Z32, Z32, N, Z32, Z6, N, N});
    add('{N, N, Z32, Z6, N, Z32, Z32, Y, N, Z32, N},
        '{N, N, Y, N, 32'h800, Z32, N, Z32, Z6, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, Y, 32'h99999999, N},
        '{N, N, N, N, 32'h800, Z32, N, Z32, Z6, N, Y});
    add('{N, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N},
        '{N, N, N, N, 32'h800, Z32, Y, 32'h99999999, 6'd1, N, N});

    repeat (2) @(posedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      drive(vecs[k].i);
      #3;
      check_out($sformatf("row%0d", k), vecs[k].o);
    end

    // ---- Starvation: loads and a store both asserted continuously ----
    begin
      logic        hs_prev;
      logic [32:0] want;
      int          n_hs, drain, cyc, n_ld, n_st;
      hs_prev = 1'b0;
      n_hs = 0; drain = 0; cyc = 0; n_ld = 0; n_st = 0;
      @(posedge clk);
      #1;
      drive('{Y, N, Z32, Z6, N, Z32, Z32, N, N, Z32, N});
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 10; k++)
        exp_q.push_back(((k % 5) == 4) ? {1'b1, 32'h2000} : {1'b0, 32'h1000});
      ld_req_valid   = 1'b1;
      ld_req_addr    = 32'h1000;
      ld_req_rob_idx = 6'd3;
      st_req_valid   = 1'b1;
      st_req_addr    = 32'h2000;
      st_req_data    = 32'hA5A5A5A5;
      mem_req_ready  = 1'b1;
      while (cyc < 300 && drain < 4) begin
        @(posedge clk);
        #1;
        mem_resp_valid = hs_prev;
        mem_resp_data  = 32'h12340000 + 32'(cyc);
        if (n_hs >= 10) begin
          ld_req_valid = 1'b0;
          st_req_valid = 1'b0;
          drain++;
        end
        #3;
        if (ld_resp_valid) n_ld++;
        if (st_done)       n_st++;
        hs_prev = mem_req_valid && mem_req_ready;
        if (hs_prev) begin
          if (exp_q.size() == 0) begin
            check_val($sformatf("starve_extra_req%0d", n_hs), {31'h0, mem_req_we, mem_req_addr}, 64'h0);
          end else begin
            want = exp_q.pop_front();
            check_val($sformatf("starve_req%0d", n_hs), {31'h0, mem_req_we, mem_req_addr}, {31'h0, want});
            if (want[32])
              check_val($sformatf("starve_wdata%0d", n_hs), {32'h0, mem_req_wdata}, 64'hA5A5A5A5);
          end
          n_hs++;
        end
        cyc++;
      end
      check_val("starve_timeout", {63'h0, drain < 4}, 64'h0);
      check_val("starve_ld_resp_count", 64'(n_ld), 64'd8);
      check_val("starve_st_done_count", 64'(n_st), 64'd2);
      check_val("starve_req_left", 64'(exp_q.size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
